// File: rtl/cell_cfg_loader_if.sv
// cell_cfg_loader_if: serial config stream in, committed config bus out
interface cell_cfg_loader_if #(parameter int TOT = 32);
    logic           start;
    logic           sdi;
    logic           sdi_valid;
    logic           sdi_ready;
    logic [TOT-1:0] cfg_out;
    logic           cfg_valid;
    logic           busy;
    logic           done;
    logic           err;
    modport master (output start, sdi, sdi_valid, input sdi_ready, cfg_out, cfg_valid, busy, done, err);
    modport slave  (input start, sdi, sdi_valid, output sdi_ready, cfg_out, cfg_valid, busy, done, err);
endinterface

// File: rtl/cell_cfg_loader.sv
// cell_cfg_loader: bit-serial config loader with even parity and atomic commit
module cell_cfg_loader #(
    parameter int N_CELLS = 4,
    parameter int CFG_W   = 8
) (
    input logic clk,
    input logic clr,
    cell_cfg_loader_if.slave bus
);
    localparam int TOT = N_CELLS * CFG_W;
    localparam int CW  = $clog2(TOT);
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
    state_t         state, nxt;
    logic [TOT-1:0] sh;
    logic [CW-1:0]  cnt;
    logic           par;
    logic           acc;
    logic           last;
    assign acc           = bus.sdi_valid & bus.sdi_ready;
    assign last          = cnt == CW'(TOT - 1);
    assign bus.sdi_ready = state != IDLE;
    assign bus.busy      = state != IDLE;
    always_ff @(posedge clk) begin
        state <= clr ? IDLE : nxt;
    end
    always_comb begin
        nxt = state;
        if (state == IDLE)
            nxt = bus.start ? SHIFT : IDLE;
        else if (acc)
            nxt = state == PARITY ? IDLE : (last ? PARITY : SHIFT);
    end
    // the applied config only changes on a parity pass, so a failed load leaves the cells untouched
    always_ff @(posedge clk) begin
        if (clr) begin
            sh            <= '0;
            cnt           <= '0;
            par           <= 1'b0;
            bus.cfg_out   <= '0;
            bus.cfg_valid <= 1'b0;
            bus.err       <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (state == IDLE && bus.start) begin
                sh      <= '0;
                cnt     <= '0;
                par     <= 1'b0;
                bus.err <= 1'b0;
            end
            if (state == SHIFT && acc) begin
                sh  <= {sh[TOT-2:0], bus.sdi};
                par <= par ^ bus.sdi;
                cnt <= last ? cnt : cnt + 1'b1;
            end
            if (state == PARITY && acc) begin
                bus.done <= 1'b1;
                if (bus.sdi == par) begin
                    bus.cfg_out   <= sh;
                    bus.cfg_valid <= 1'b1;
                    bus.err       <= 1'b0;
                end else begin
                    bus.err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/cell_cfg_loader.md
# cell_cfg_loader

Serial configuration loader that sits directly upstream of the mux-based logic cells (s1/s2/c1 types) and produces their static configuration inputs. It accepts a bit-serial configuration stream under a valid/ready handshake, checks a trailing even-parity bit, and commits the whole configuration atomically to a parallel output bus. The bus drives the cells' data and select inputs. A failed load never disturbs the configuration currently applied to the cells.

## Interface
Parameters:
- N_CELLS, 4: number of cells configured.
- CFG_W, 8: configuration bits per cell.
- TOT = N_CELLS*CFG_W (localparam): payload bits per load.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- clr  in  1  reset, synchronous and active-high.
- start  in  1  begin a load; sampled only in IDLE.
- sdi  in  1  serial data bit.
- sdi_valid  in  1  sdi carries a bit this cycle.
- sdi_ready  out  1  loader accepts a bit this cycle.
- cfg_out  out  TOT  committed configuration. Cell k occupies [k*CFG_W +: CFG_W].
  - Per-cell map for CFG_W=8: [0]=D00, [1]=D01, [2]=D10, [3]=D11, [4]=A1, [5]=B1, [6]=A0, [7]=B0.
- cfg_valid  out  1  cfg_out holds a successfully committed configuration.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse at the end of any load, pass or fail.
- err  out  1  the last load failed parity; sticky.

## Operation
- Accept event = sdi_valid & sdi_ready.
- States:
  - IDLE: sdi_ready=0, busy=0.
    - start=1 → SHIFT.
    - On the same edge: clear shift register, bit counter and parity accumulator; clear err.
  - SHIFT: sdi_ready=1, busy=1.
    - Each accept: shift_reg <= {shift_reg[TOT-2:0], sdi}; par <= par ^ sdi; cnt <= cnt+1.
    - Accept while cnt==TOT-1 → PARITY.
  - PARITY: sdi_ready=1, busy=1.
    - On accept with sdi==par: cfg_out <= shift_reg, cfg_valid <= 1, err <= 0.
    - On accept with sdi!=par: err <= 1; cfg_out and cfg_valid are unchanged.
    - Either way: done <= 1, → IDLE.
- Bit order: the first payload bit received ends at cfg_out[TOT-1], the last at cfg_out[0] (MSB first).
- The parity bit equals the XOR of all TOT payload bits (even parity over payload plus parity bit).
- start is ignored in SHIFT and PARITY.
- cfg_valid, once set, stays high through later loads (pass or fail); only clr clears it.
- cnt width is clog2(TOT); it never wraps within a load.

## Timing
- Reset values: sdi_ready=0, busy=0, done=0, err=0, cfg_valid=0, cfg_out=0; state IDLE.
- clr has priority over every other input in every state. Asserting it mid-load abandons the load and produces no done pulse.
- Ready/busy:
  - start sampled at edge E0; sdi_ready and busy are high from the cycle after E0.
  - sdi_ready drops in the cycle after the parity-bit accept edge.
- Minimum load time: start edge, then TOT+1 accept edges. With sdi_valid held high this is TOT+2 cycles from start to done.
- Commit:
  - cfg_out, cfg_valid and err update on the parity-accept edge.
  - done is high for exactly the one following cycle.
- A start during the done cycle is accepted (the state is IDLE), giving back-to-back loads.
- sdi_valid gaps stall the load indefinitely with no timeout. sdi is ignored whenever sdi_valid=0 or sdi_ready=0.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
Parameters for all scenarios: N_CELLS=4, CFG_W=8, TOT=32.
- **Reset:** clr high 2 cycles, then idle → all outputs 0, sdi_ready=0. A stray sdi_valid=1 in IDLE has no effect.
- **Good load:** start, then stream 0xA5C30F81 MSB first, then parity 0, sdi_valid held high → done pulses 34 cycles after start; cfg_out=0xA5C30F81, cfg_valid=1, err=0; cell 0 has D00=1, B0=1.
- **Bad parity:** after the good load, reload 0x12345678 with parity 0 (correct parity is 1) → done=1, err=1, cfg_out still 0xA5C30F81, cfg_valid=1. A following start clears err.
- **Gapped stream:** same 0xA5C30F81 load with sdi_valid toggling every other cycle and garbage on sdi while invalid → identical result; done 67 cycles after start.
- **Abort and ignored start:** pulse start again at bit 10 → ignored, load continues. Assert clr at bit 17 → all outputs 0 the next cycle, no done. A fresh load of 0xFFFF0000 with parity 0 → cfg_out=0xFFFF0000.
- **Back-to-back:** assert start in the done cycle of a good load → busy is high the next cycle; the second load of 0x00000001 with parity 1 commits cleanly.
